// File: rtl/alu_issue_wb.sv
// Single-issue ALU sequencer: register file, IDLE/EXEC/WB control,
// operand drive to an external combinational ALU and sticky carry flag.
module alu_issue_wb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              done,
    output logic [DATA_W-1:0] wb_data,
    output logic              carry_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_rf [NREG];
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_res;
    logic              r_cy;
    logic              r_carry;
    logic              w_accept;
    logic              w_wb;
    logic              w_carry_op;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    // r0 is hardwired to zero on every read port
    assign w_rs1_val = (in_rs1 == '0) ? '0 : r_rf[in_rs1];
    assign w_rs2_val = (in_rs2 == '0) ? '0 : r_rf[in_rs2];
    assign dbg_data  = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

    assign in_ready   = (r_state == S_IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_wb       = (r_state == S_WB);
    assign w_carry_op = (r_op == 4'b0000) || (r_op == 4'b0001);

    assign alu_ctrl   = r_op;
    assign alu_x      = r_x;
    assign alu_y      = r_y;
    assign done       = w_wb;
    assign wb_data    = r_res;
    assign carry_flag = r_carry;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operands are sampled at accept and held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= '0;
            r_rd <= '0;
            r_x  <= '0;
            r_y  <= '0;
        end else if (w_accept) begin
            r_op <= in_op;
            r_rd <= in_rd;
            r_x  <= w_rs1_val;
            r_y  <= w_rs2_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
            r_cy  <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_res <= alu_out;
            r_cy  <= alu_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (w_wb && w_carry_op) begin
            r_carry <= r_cy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wb && (r_rd != '0)) begin
            r_rf[r_rd] <= r_res;
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb with a small behavioural ALU attached.
module tb_alu_issue_wb;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [2:0] in_rd;
    logic [2:0] in_rs1;
    logic [2:0] in_rs2;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       done;
    logic [7:0] wb_data;
    logic       carry_flag;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_pass;
    int n_total;
    int n_done;

    alu_issue_wb #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_rd(in_rd),
        .in_rs1(in_rs1),
        .in_rs2(in_rs2),
        .alu_ctrl(alu_ctrl),
        .alu_x(alu_x),
        .alu_y(alu_y),
        .alu_out(alu_out),
        .alu_carry(alu_carry),
        .done(done),
        .wb_data(wb_data),
        .carry_flag(carry_flag),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done) n_done++;

    // Bench ALU: 0 add, 1 sub, 2 and, 3 inc, 4 not, 5 shl,
    // 6 shl-in-1, 7 or, 8 nibble pack, others 0
    always_comb begin
        logic [8:0] t;
        t = '0;
        unique case (alu_ctrl)
            4'h0: t = {1'b0, alu_x} + {1'b0, alu_y};
            4'h1: t = {1'b0, alu_x} - {1'b0, alu_y};
            4'h2: t = {1'b0, alu_x & alu_y};
            4'h3: t = {1'b0, alu_x + 8'd1};
            4'h4: t = {1'b0, ~alu_x};
            4'h5: t = {1'b0, alu_x[6:0], 1'b0};
            4'h6: t = {1'b0, alu_x[6:0], 1'b1};
            4'h7: t = {1'b0, alu_x | alu_y};
            4'h8: t = {1'b0, alu_x[3:0], alu_y[3:0]};
            default: t = '0;
        endcase
        alu_out   = t[7:0];
        alu_carry = t[8];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic run(input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [7:0] ex, input logic [7:0] ey,
                       input logic [7:0] eres);
        @(negedge clk);
        check("ready_idle", in_ready, 1);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("exec_ready", in_ready, 0);
        check("exec_done", done, 0);
        check("alu_ctrl", alu_ctrl, op);
        check("alu_x", alu_x, ex);
        check("alu_y", alu_y, ey);
        @(negedge clk);
        check("wb_done", done, 1);
        check("wb_data", wb_data, eres);
        @(negedge clk);
        dbg_addr = rd;
        #1;
        check("rf_rd", dbg_data, (rd == 3'd0) ? 8'h00 : eres);
    endtask

    initial begin
        int base;
        n_pass = 0; n_total = 0; n_done = 0;
        rst_n = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        dbg_addr = '0;
        #2;
        check("rst_ready", in_ready, 1);
        check("rst_done", done, 0);
        check("rst_cf", carry_flag, 0);
        check("rst_wb", wb_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // seed r1=0x0F, r2=0xF1
        run(4'h6, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 8'h01);
        run(4'h6, 3'd1, 3'd1, 3'd0, 8'h01, 8'h00, 8'h03);
        run(4'h6, 3'd1, 3'd1, 3'd0, 8'h03, 8'h00, 8'h07);
        run(4'h6, 3'd1, 3'd1, 3'd0, 8'h07, 8'h00, 8'h0F);
        run(4'h4, 3'd2, 3'd1, 3'd0, 8'h0F, 8'h00, 8'hF0);
        run(4'h3, 3'd2, 3'd2, 3'd0, 8'hF0, 8'h00, 8'hF1);
        check("cf_before_add", carry_flag, 0);
        run(4'h0, 3'd3, 3'd1, 3'd2, 8'h0F, 8'hF1, 8'h00);
        check("cf_add", carry_flag, 1);

        // seed r1=0x05, r2=0x07
        run(4'h6, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 8'h01);
        run(4'h5, 3'd1, 3'd1, 3'd0, 8'h01, 8'h00, 8'h02);
        run(4'h6, 3'd1, 3'd1, 3'd0, 8'h02, 8'h00, 8'h05);
        run(4'h6, 3'd2, 3'd0, 3'd0, 8'h00, 8'h00, 8'h01);
        run(4'h6, 3'd2, 3'd2, 3'd0, 8'h01, 8'h00, 8'h03);
        run(4'h6, 3'd2, 3'd2, 3'd0, 8'h03, 8'h00, 8'h07);
        run(4'h0, 3'd4, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        check("cf_add_nc", carry_flag, 0);
        run(4'h1, 3'd4, 3'd1, 3'd2, 8'h05, 8'h07, 8'hFE);
        check("cf_sub", carry_flag, 1);
        run(4'h2, 3'd6, 3'd4, 3'd2, 8'hFE, 8'h07, 8'h06);
        check("cf_and_hold", carry_flag, 1);

        // r5=0x81 then write to r0
        run(4'h3, 3'd6, 3'd2, 3'd0, 8'h07, 8'h00, 8'h08);
        run(4'h6, 3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 8'h01);
        run(4'h8, 3'd5, 3'd6, 3'd7, 8'h08, 8'h01, 8'h81);
        run(4'h7, 3'd0, 3'd0, 3'd5, 8'h00, 8'h81, 8'h81);
        dbg_addr = 3'd5;
        #1 check("r5", dbg_data, 8'h81);

        // op 1111 zeroes rd, carry kept
        run(4'hF, 3'd4, 3'd1, 3'd2, 8'h05, 8'h07, 8'h00);
        check("cf_opf_hold", carry_flag, 1);

        // back-to-back with in_valid held high, RAW on r6
        @(negedge clk);
        check("b2b_ready0", in_ready, 1);
        in_op = 4'h3; in_rd = 3'd6; in_rs1 = 3'd6; in_rs2 = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_op = 4'h7; in_rd = 3'd7; in_rs1 = 3'd6; in_rs2 = 3'd0;
        check("b2b_ready1", in_ready, 0);
        check("b2b_hold_x", alu_x, 8'h08);
        check("b2b_hold_op", alu_ctrl, 4'h3);
        @(negedge clk);
        check("b2b_ready2", in_ready, 0);
        check("b2b_wb_a", wb_data, 8'h09);
        @(negedge clk);
        check("b2b_ready3", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_x_raw", alu_x, 8'h09);
        check("b2b_op_b", alu_ctrl, 4'h7);
        @(negedge clk);
        check("b2b_done_b", done, 1);
        check("b2b_wb_b", wb_data, 8'h09);
        @(negedge clk);
        dbg_addr = 3'd7;
        #1 check("b2b_r7", dbg_data, 8'h09);

        // reset during EXEC aborts the instruction
        @(negedge clk);
        base = n_done;
        in_op = 4'h7; in_rd = 3'd3; in_rs1 = 3'd5; in_rs2 = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_x_pre", alu_x, 8'h81);
        rst_n = 1'b0;
        #1;
        check("abort_x", alu_x, 0);
        check("abort_y", alu_y, 0);
        check("abort_ctrl", alu_ctrl, 0);
        check("abort_done", done, 0);
        check("abort_wb", wb_data, 0);
        check("abort_cf", carry_flag, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", in_ready, 1);
        check("abort_no_done", n_done - base, 0);
        dbg_addr = 3'd3;
        #1 check("abort_r3", dbg_data, 0);
        dbg_addr = 3'd5;
        #1 check("abort_r5", dbg_data, 0);

        run(4'h6, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
